// File: rtl/pacman_pkg.sv
// Shared Pac-Man definitions: direction encoding, screen geometry and the
// W > S > A > D priority used by both the input stage and Player.
package pacman_pkg;

  typedef enum logic [1:0] {
    DIR_W = 2'd0,
    DIR_S = 2'd1,
    DIR_A = 2'd2,
    DIR_D = 2'd3
  } dir_e;

  localparam int unsigned WIDTH     = 640;
  localparam int unsigned HEIGHT    = 480;
  localparam int unsigned TILE_SIZE = 20;

  // keys is indexed by dir_e; the lowest index set wins.
  function automatic dir_e prio_dir(input logic [3:0] keys);
    dir_e sel;
    if (keys[DIR_W])      sel = DIR_W;
    else if (keys[DIR_S]) sel = DIR_S;
    else if (keys[DIR_A]) sel = DIR_A;
    else                  sel = DIR_D;
    return sel;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One button: two-flop synchroniser, stability counter, debounced level and
// a one-cycle press strobe coincident with the stable 1->0 flip.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic key_n_i,
  output logic level_n_o,
  output logic press_o
);

  localparam int unsigned DbW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic           sync1_q, sync2_q;
  logic           stable_q, stable_d;
  logic [DbW-1:0] cnt_q, cnt_d;
  logic           flip;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= key_n_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    flip     = 1'b0;
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == DbW'(DEBOUNCE_CYCLES - 1)) begin
        flip     = 1'b1;
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Pulses in the cycle the flip is decided, one cycle before the level moves.
  assign press_o   = flip & ~sync2_q;
  assign level_n_o = stable_q;

endmodule

// File: rtl/player_input_ctrl.sv
// WASD front end for Player: debounces four keys, latches short presses and
// issues one prioritised move command per movement tick.
module player_input_ctrl
  import pacman_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned TICK_CYCLES     = 833333,
  parameter int unsigned CNT_W           = $clog2(TICK_CYCLES)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       key_w_n,
  input  logic       key_a_n,
  input  logic       key_s_n,
  input  logic       key_d_n,
  output logic       w,
  output logic       a,
  output logic       s,
  output logic       d,
  output logic [1:0] dir,
  output logic       dir_valid,
  output logic       move_tick
);

  // All per-key vectors are indexed by dir_e.
  logic [3:0] raw_n, held_n, held, press;

  assign raw_n = {key_d_n, key_a_n, key_s_n, key_w_n};

  for (genvar i = 0; i < 4; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debounce (
      .clk_i    (clk),
      .reset_i  (reset),
      .key_n_i  (raw_n[i]),
      .level_n_o(held_n[i]),
      .press_o  (press[i])
    );
  end

  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic             move_tick_q, move_tick_d;
  logic             pending_valid_q, pending_valid_d;
  dir_e             pending_dir_q, pending_dir_d;
  logic [3:0]       cmd_n_q, cmd_n_d;
  dir_e             dir_q, dir_d;
  logic             dir_valid_q, dir_valid_d;
  logic             tick_now;
  logic             issue_valid;
  dir_e             issue_dir;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt_q      <= '0;
      move_tick_q     <= 1'b0;
      pending_valid_q <= 1'b0;
      pending_dir_q   <= DIR_W;
      cmd_n_q         <= 4'hF;
      dir_q           <= DIR_W;
      dir_valid_q     <= 1'b0;
    end else begin
      tick_cnt_q      <= tick_cnt_d;
      move_tick_q     <= move_tick_d;
      pending_valid_q <= pending_valid_d;
      pending_dir_q   <= pending_dir_d;
      cmd_n_q         <= cmd_n_d;
      dir_q           <= dir_d;
      dir_valid_q     <= dir_valid_d;
    end
  end

  always_comb begin
    held     = ~held_n;
    tick_now = run && (tick_cnt_q == CNT_W'(TICK_CYCLES - 1));

    // A press arriving in the decision cycle is newer than anything pending.
    issue_valid = 1'b1;
    if (|held)       issue_dir = prio_dir(held);
    else if (|press) issue_dir = prio_dir(press);
    else begin
      issue_dir   = pending_dir_q;
      issue_valid = pending_valid_q;
    end

    tick_cnt_d      = tick_cnt_q;
    move_tick_d     = tick_now;
    pending_valid_d = pending_valid_q;
    pending_dir_d   = pending_dir_q;
    cmd_n_d         = cmd_n_q;
    dir_d           = dir_q;
    dir_valid_d     = dir_valid_q;

    if (run) tick_cnt_d = tick_now ? '0 : tick_cnt_q + 1'b1;

    if (tick_now) begin
      pending_valid_d = 1'b0;
      cmd_n_d         = 4'hF;
      dir_valid_d     = issue_valid;
      if (issue_valid) begin
        cmd_n_d = ~(4'b0001 << issue_dir);
        dir_d   = issue_dir;
      end
    end else if (|press) begin
      pending_valid_d = 1'b1;
      pending_dir_d   = prio_dir(press);
    end
  end

  assign w         = cmd_n_q[DIR_W];
  assign s         = cmd_n_q[DIR_S];
  assign a         = cmd_n_q[DIR_A];
  assign d         = cmd_n_q[DIR_D];
  assign dir       = dir_q;
  assign dir_valid = dir_valid_q;
  assign move_tick = move_tick_q;

endmodule

// File: tb/tb_player_input_ctrl.sv
// Scoreboard bench: expected tick commands are queued as keys are driven and
// compared whenever move_tick fires.
module tb_player_input_ctrl;

  localparam int unsigned DebounceCycles = 4;
  localparam int unsigned TickCycles     = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b1;
  logic       key_w_n = 1'b1, key_a_n = 1'b1, key_s_n = 1'b1, key_d_n = 1'b1;
  logic       w, a, s, d, dir_valid, move_tick;
  logic [1:0] dir;

  int         n_vec = 0;
  int         n_err = 0;
  logic [6:0] exp_q[$];
  string      tag_q[$];

  always #5 clk = ~clk;

  player_input_ctrl #(
    .DEBOUNCE_CYCLES(DebounceCycles),
    .TICK_CYCLES    (TickCycles)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .key_w_n  (key_w_n),
    .key_a_n  (key_a_n),
    .key_s_n  (key_s_n),
    .key_d_n  (key_d_n),
    .w        (w),
    .a        (a),
    .s        (s),
    .d        (d),
    .dir      (dir),
    .dir_valid(dir_valid),
    .move_tick(move_tick)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Packs {w,a,s,d,dir,dir_valid}.
  function automatic logic [6:0] cmd(input int dr, input bit valid);
    logic [3:0] wasd;
    wasd = 4'hF;
    if (valid) begin
      case (dr)
        0:       wasd[3] = 1'b0;
        1:       wasd[1] = 1'b0;
        2:       wasd[2] = 1'b0;
        default: wasd[0] = 1'b0;
      endcase
    end
    return {wasd, 2'(dr), valid};
  endfunction

  task automatic expect_tick(input string tag, input logic [6:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!move_tick && n < 40);
    if (!move_tick) check_eq("tick_timeout", 32'(move_tick), 32'd1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check_eq("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      tag_q.delete();
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (!reset && move_tick && exp_q.size() > 0) begin
      check_eq(tag_q.pop_front(), 32'({w, a, s, d, dir, dir_valid}), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_tick;

    repeat (3) @(negedge clk);
    check_eq("reset_state", 32'({w, a, s, d, dir, dir_valid, move_tick}), 32'(8'hF0));
    reset = 1'b0;

    // 3-cycle glitch on A is filtered out.
    wait_tick();
    key_a_n = 1'b0;
    repeat (3) @(negedge clk);
    key_a_n = 1'b1;
    expect_tick("glitch_a_idle", cmd(0, 1'b0));
    wait_drain();

    // Short D press lands and releases between decisions: served from pending.
    wait_tick();
    repeat (5) @(negedge clk);
    key_d_n = 1'b0;
    repeat (6) @(negedge clk);
    key_d_n = 1'b1;
    expect_tick("pending_d", cmd(3, 1'b1));
    expect_tick("pending_d_idle", cmd(3, 1'b0));
    wait_drain();

    // A press in the decision cycle is bypassed and not left pending.
    wait_tick();
    repeat (4) @(negedge clk);
    key_a_n = 1'b0;
    expect_tick("bypass_a", cmd(2, 1'b1));
    expect_tick("bypass_a_consumed", cmd(2, 1'b0));
    repeat (6) @(negedge clk);
    key_a_n = 1'b1;
    wait_drain();

    // W and D held together: W wins until released.
    wait_tick();
    key_w_n = 1'b0;
    key_d_n = 1'b0;
    expect_tick("wd_held_1", cmd(0, 1'b1));
    expect_tick("wd_held_2", cmd(0, 1'b1));
    wait_drain();
    key_w_n = 1'b1;
    expect_tick("d_after_w_release", cmd(3, 1'b1));
    wait_drain();
    key_d_n = 1'b1;
    expect_tick("all_released", cmd(3, 1'b0));
    wait_drain();

    // run = 0 freezes the tick counter with S held.
    wait_tick();
    key_s_n = 1'b0;
    repeat (2) @(negedge clk);
    run = 1'b0;
    n_tick = 0;
    repeat (25) begin
      @(negedge clk);
      if (move_tick) n_tick++;
    end
    check_eq("frozen_no_tick", 32'(n_tick), 32'd0);
    expect_tick("resume_s", cmd(1, 1'b1));
    run = 1'b1;
    repeat (7) @(negedge clk);
    check_eq("resume_not_early", 32'(move_tick), 32'd0);
    @(negedge clk);
    check_eq("resume_from_frozen", 32'(move_tick), 32'd1);
    key_s_n = 1'b1;
    wait_drain();

    // Reset mid-run with W held.
    wait_tick();
    key_w_n = 1'b0;
    expect_tick("w_before_reset", cmd(0, 1'b1));
    wait_drain();
    #1 reset = 1'b1;
    #1 check_eq("reset_async", 32'({w, a, s, d, dir, dir_valid, move_tick}), 32'(8'hF0));
    @(negedge clk);
    reset = 1'b0;
    expect_tick("w_after_reset", cmd(0, 1'b1));
    repeat (9) @(negedge clk);
    check_eq("reset_no_early_tick", 32'(move_tick), 32'd0);
    @(negedge clk);
    check_eq("reset_first_tick", 32'(move_tick), 32'd1);
    wait_drain();
    key_w_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
